// File: rtl/audio_pkg.sv
// Shared constants for the sound-effect mixer: effect codes, FSM encoding and
// tone half-periods, which are derived from the clock frequency.
package audio_pkg;

    localparam int CLK_HZ_NOM = 100_000_000;

    localparam int F_MOVE   = 440;
    localparam int F_MERGE  = 660;
    localparam int F_WIN_A  = 880;
    localparam int F_WIN_B  = 1320;
    localparam int F_LOSE_A = 330;
    localparam int F_LOSE_B = 220;

    localparam logic [1:0] SFX_MOVE  = 2'd0;
    localparam logic [1:0] SFX_MERGE = 2'd1;
    localparam logic [1:0] SFX_WIN   = 2'd2;
    localparam logic [1:0] SFX_LOSE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TONE_A = 2'd1,
        ST_TONE_B = 2'd2
    } sfx_state_e;

    // Rounded clk_hz / (2 * freq_hz): clocks per half cycle of the square wave.
    function automatic logic [17:0] half_period(input int clk_hz, input int freq_hz);
        return 18'((clk_hz + freq_hz) / (2 * freq_hz));
    endfunction

    localparam logic [17:0] HP_MOVE   = half_period(CLK_HZ_NOM, F_MOVE);
    localparam logic [17:0] HP_MERGE  = half_period(CLK_HZ_NOM, F_MERGE);
    localparam logic [17:0] HP_WIN_A  = half_period(CLK_HZ_NOM, F_WIN_A);
    localparam logic [17:0] HP_WIN_B  = half_period(CLK_HZ_NOM, F_WIN_B);
    localparam logic [17:0] HP_LOSE_A = half_period(CLK_HZ_NOM, F_LOSE_A);
    localparam logic [17:0] HP_LOSE_B = half_period(CLK_HZ_NOM, F_LOSE_B);

endpackage

// File: rtl/pwm_dac.sv
// 8-bit PWM DAC: free-running 256-clock period, level latched once per period
// so the duty cycle never changes mid-period.
module pwm_dac (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] level_i,
    output logic       pwm_o
);

    logic [7:0] pwmCnt_q;
    logic [7:0] sample_q;
    logic       out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwmCnt_q <= 8'd0;
            sample_q <= 8'd128;
            out_q    <= 1'b0;
        end else begin
            pwmCnt_q <= pwmCnt_q + 8'd1;
            if (pwmCnt_q == 8'hFF) begin
                sample_q <= level_i;
            end
            out_q <= (pwmCnt_q < sample_q);
        end
    end

    assign pwm_o = out_q;

endmodule

// File: rtl/sfx_mixer.sv
// Mixes the background-music square wave with a decaying one- or two-tone
// sound effect and drives the audio pin through an 8-bit PWM DAC.
module sfx_mixer
    import audio_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int BGM_AMP  = 48,
    parameter int ENV_MAX  = 96,
    parameter int ENV_STEP = 65_536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bgmIn,
    input  logic       bgmEnable,
    input  logic       sfxTrigger,
    input  logic [1:0] sfxSel,
    output logic       audioOut,
    output logic       audSd,
    output logic       sfxBusy
);

    localparam int ENV_W  = $clog2(ENV_MAX + 1);
    localparam int STEP_W = (ENV_STEP > 1) ? $clog2(ENV_STEP) : 1;

    localparam logic [ENV_W-1:0]  ENV_FULL  = ENV_W'(ENV_MAX);
    localparam logic [ENV_W-1:0]  ENV_HALF  = ENV_W'(ENV_MAX / 2);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(ENV_STEP - 1);

    localparam logic [17:0] HP_MOVE_C   = half_period(CLK_HZ, F_MOVE);
    localparam logic [17:0] HP_MERGE_C  = half_period(CLK_HZ, F_MERGE);
    localparam logic [17:0] HP_WIN_A_C  = half_period(CLK_HZ, F_WIN_A);
    localparam logic [17:0] HP_WIN_B_C  = half_period(CLK_HZ, F_WIN_B);
    localparam logic [17:0] HP_LOSE_A_C = half_period(CLK_HZ, F_LOSE_A);
    localparam logic [17:0] HP_LOSE_B_C = half_period(CLK_HZ, F_LOSE_B);

    localparam logic signed [9:0] BGM_P = 10'(BGM_AMP);

    function automatic logic [7:0] sat_u8(input logic signed [9:0] v);
        if (v < 10'sd0) begin
            return 8'd0;
        end else if (v > 10'sd255) begin
            return 8'hFF;
        end
        return v[7:0];
    endfunction

    sfx_state_e         state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [ENV_W-1:0]   env_q, env_d, envDec;
    logic [STEP_W-1:0]  stepCnt_q, stepCnt_d;
    logic [17:0]        toneCnt_q, toneCnt_d, halfPeriod;
    logic               toneBit_q, toneBit_d;

    logic signed [9:0]  bgmTerm, sfxTerm, envS, mix;
    logic [7:0]         level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= SFX_MOVE;
            env_q     <= '0;
            stepCnt_q <= '0;
            toneCnt_q <= '0;
            toneBit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            env_q     <= env_d;
            stepCnt_q <= stepCnt_d;
            toneCnt_q <= toneCnt_d;
            toneBit_q <= toneBit_d;
        end
    end

    always_comb begin
        halfPeriod = HP_MOVE_C;
        case (sel_q)
            SFX_MOVE:  halfPeriod = HP_MOVE_C;
            SFX_MERGE: halfPeriod = HP_MERGE_C;
            SFX_WIN:   halfPeriod = (state_q == ST_TONE_B) ? HP_WIN_B_C : HP_WIN_A_C;
            SFX_LOSE:  halfPeriod = (state_q == ST_TONE_B) ? HP_LOSE_B_C : HP_LOSE_A_C;
            default:   halfPeriod = HP_MOVE_C;
        endcase
    end

    // A trigger always wins, including over the final envelope step.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        env_d     = env_q;
        stepCnt_d = stepCnt_q;
        toneCnt_d = toneCnt_q;
        toneBit_d = toneBit_q;
        envDec    = env_q - ENV_W'(1);

        if (sfxTrigger) begin
            state_d   = ST_TONE_A;
            sel_d     = sfxSel;
            env_d     = ENV_FULL;
            stepCnt_d = '0;
            toneCnt_d = '0;
            toneBit_d = 1'b1;
        end else if (state_q != ST_IDLE) begin
            if (toneCnt_q == halfPeriod - 18'd1) begin
                toneCnt_d = '0;
                toneBit_d = ~toneBit_q;
            end else begin
                toneCnt_d = toneCnt_q + 18'd1;
            end

            if (stepCnt_q == STEP_LAST) begin
                stepCnt_d = '0;
                env_d     = envDec;
                if (envDec == '0) begin
                    state_d = ST_IDLE;
                end else if (state_q == ST_TONE_A && sel_q[1] && envDec == ENV_HALF) begin
                    // Second tone starts a fresh cycle but keeps the current phase level.
                    state_d   = ST_TONE_B;
                    toneCnt_d = '0;
                    toneBit_d = toneBit_q;
                end
            end else begin
                stepCnt_d = stepCnt_q + STEP_W'(1);
            end
        end
    end

    assign envS = signed'(10'(env_q));

    always_comb begin
        bgmTerm = '0;
        if (bgmEnable) begin
            bgmTerm = bgmIn ? BGM_P : -BGM_P;
        end
        sfxTerm = '0;
        if (state_q != ST_IDLE) begin
            sfxTerm = toneBit_q ? envS : -envS;
        end
        mix   = 10'sd128 + bgmTerm + sfxTerm;
        level = sat_u8(mix);
    end

    pwm_dac u_dac (
        .clk     (clk),
        .reset   (reset),
        .level_i (level),
        .pwm_o   (audioOut)
    );

    assign audSd   = 1'b1;
    assign sfxBusy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sfx_mixer.sv
// Directed bench for sfx_mixer with a reduced clock (fast tones) and a short
// envelope step; expected values are hand-computed for these parameters.
module tb_sfx_mixer;
    import audio_pkg::*;

    // CLK_HZ = 100_000 gives half-periods: move 114, merge 76, win 57/38, lose 152/227.
    localparam int STEP = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bgmIn = 1'b0;
    logic       bgmEnable = 1'b0;
    logic       sfxTrigger = 1'b0;
    logic [1:0] sfxSel = 2'd0;
    logic       audioOut, audSd, sfxBusy;

    int n_chk = 0;
    int n_err = 0;

    sfx_mixer #(
        .CLK_HZ   (100_000),
        .BGM_AMP  (48),
        .ENV_MAX  (96),
        .ENV_STEP (STEP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bgmIn      (bgmIn),
        .bgmEnable  (bgmEnable),
        .sfxTrigger (sfxTrigger),
        .sfxSel     (sfxSel),
        .audioOut   (audioOut),
        .audSd      (audSd),
        .sfxBusy    (sfxBusy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic count_high(output int n);
        n = 0;
        repeat (256) begin
            @(negedge clk);
            if (audioOut === 1'b1) n++;
        end
    endtask

    task automatic trig(input logic [1:0] sel);
        sfxSel     = sel;
        sfxTrigger = 1'b1;
        @(negedge clk);
        sfxTrigger = 1'b0;
    endtask

    task automatic align_pwm(input logic [7:0] target, output logic found);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (dut.u_dac.pwmCnt_q == target) found = 1'b1;
        end
    endtask

    task automatic wait_idle(output logic found);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (sfxBusy === 1'b0) found = 1'b1;
            else @(negedge clk);
        end
    endtask

    initial begin
        int   n, t1, t2, tbIdx, togIdx;
        logic prevBit, tbBit, found;

        repeat (3) @(negedge clk);
        check_val("rst_audioOut", 32'(audioOut), 0);
        check_val("rst_audSd", 32'(audSd), 1);
        check_val("rst_busy", 32'(sfxBusy), 0);
        check_val("rst_sample", 32'(dut.u_dac.sample_q), 128);
        reset = 1'b0;

        count_high(n);
        check_val("idle_duty", 32'(n), 128);
        check_val("idle_busy", 32'(sfxBusy), 0);

        bgmEnable = 1'b1;
        bgmIn     = 1'b1;
        repeat (512) @(negedge clk);
        count_high(n);
        check_val("bgm_high_duty", 32'(n), 176);
        bgmIn = 1'b0;
        repeat (512) @(negedge clk);
        count_high(n);
        check_val("bgm_low_duty", 32'(n), 80);
        bgmEnable = 1'b0;

        // Merge: sel changed after the trigger must not affect the latched effect.
        trig(SFX_MERGE);
        sfxSel = SFX_MOVE;
        check_val("merge_tonebit_start", 32'(dut.toneBit_q), 1);
        n = 0; t1 = 0; t2 = 0;
        prevBit = dut.toneBit_q;
        for (int i = 1; i <= 2000 && sfxBusy; i++) begin
            n++;
            if (dut.toneBit_q !== prevBit) begin
                if (t1 == 0) t1 = i;
                else if (t2 == 0) t2 = i;
            end
            prevBit = dut.toneBit_q;
            @(negedge clk);
        end
        check_val("merge_busy_len", 32'(n), 768);
        check_val("merge_toggle1", 32'(t1), 77);
        check_val("merge_toggle2", 32'(t2), 153);
        check_val("merge_env_end", 32'(dut.env_q), 0);
        check_val("merge_state_end", 32'(dut.state_q), 32'(ST_IDLE));

        // Win: second tone at env 48, phase kept, 38-clock half period.
        trig(SFX_WIN);
        n = 0; tbIdx = 0; togIdx = 0; tbBit = 1'b0;
        for (int i = 1; i <= 2000 && sfxBusy; i++) begin
            n++;
            if (tbIdx == 0 && dut.state_q == ST_TONE_B) begin
                tbIdx = i;
                tbBit = dut.toneBit_q;
            end else if (tbIdx != 0 && togIdx == 0 && dut.toneBit_q !== tbBit) begin
                togIdx = i;
            end
            @(negedge clk);
        end
        check_val("win_toneb_idx", 32'(tbIdx), 385);
        check_val("win_toneb_bit", 32'(tbBit), 1);
        check_val("win_toneb_toggle", 32'(togIdx), 423);
        check_val("win_busy_len", 32'(n), 768);

        // Saturation high: mix 128+48+96 = 272 latched five clocks after the trigger.
        bgmEnable = 1'b1;
        bgmIn     = 1'b1;
        align_pwm(8'd250, found);
        check_val("sat_hi_align", 32'(found), 1);
        trig(SFX_MOVE);
        repeat (5) @(negedge clk);
        check_val("sat_hi_sample", 32'(dut.u_dac.sample_q), 255);
        count_high(n);
        check_val("sat_hi_duty", 32'(n), 255);

        // Saturation low: win tone low phase, env 89 -> mix 128-48-89 = -9.
        bgmIn = 1'b0;
        align_pwm(8'd195, found);
        check_val("sat_lo_align", 32'(found), 1);
        trig(SFX_WIN);
        repeat (60) @(negedge clk);
        check_val("sat_lo_sample", 32'(dut.u_dac.sample_q), 0);
        count_high(n);
        check_val("sat_lo_duty", 32'(n), 0);
        wait_idle(found);
        check_val("sat_lo_idle", 32'(found), 1);

        // Retrigger mid-effect at env 10.
        bgmEnable = 1'b0;
        trig(SFX_LOSE);
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (dut.env_q == 10) found = 1'b1;
            else @(negedge clk);
        end
        check_val("retrig_reach_env10", 32'(found), 1);
        trig(SFX_LOSE);
        check_val("retrig_env", 32'(dut.env_q), 96);
        check_val("retrig_state", 32'(dut.state_q), 32'(ST_TONE_A));
        check_val("retrig_busy", 32'(sfxBusy), 1);

        // Trigger on the same clock as the final envelope decrement.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (dut.env_q == 1 && dut.stepCnt_q == STEP - 1) found = 1'b1;
            else @(negedge clk);
        end
        check_val("last_step_reach", 32'(found), 1);
        trig(SFX_MOVE);
        check_val("last_step_state", 32'(dut.state_q), 32'(ST_TONE_A));
        check_val("last_step_env", 32'(dut.env_q), 96);
        check_val("last_step_sel", 32'(dut.sel_q), 32'(SFX_MOVE));

        // Asynchronous reset mid-effect, observed before the next rising edge.
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (audioOut === 1'b1) found = 1'b1;
        end
        check_val("rst_mid_audio_high", 32'(found), 1);
        reset = 1'b1;
        #1;
        check_val("rst_mid_audioOut", 32'(audioOut), 0);
        check_val("rst_mid_busy", 32'(sfxBusy), 0);
        check_val("rst_mid_state", 32'(dut.state_q), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        count_high(n);
        check_val("post_rst_duty", 32'(n), 128);
        check_val("post_rst_busy", 32'(sfxBusy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
